// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetches instructions over a valid handshake, issues ordinary ones to the datapath,
// resolves jumps internally and pulses the PC advance controls for one cycle per instruction.
module fetch_sequencer #(
  parameter int ADDR_W = 11,
  parameter int INSTR_W = 16,
  parameter logic [3:0] OPC_JMP = 4'hE,
  parameter logic [3:0] OPC_JCMP = 4'hF,
  parameter logic [3:0] OPC_HALT = 4'hD
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [ADDR_W-1:0]        pc,
  output logic [ADDR_W-1:0]        imem_addr,
  output logic                     imem_rd,
  input  logic [INSTR_W-1:0]       imem_data,
  input  logic                     imem_valid,
  input  logic                     flag_zero,
  input  logic                     flag_neg,
  input  logic                     exec_done,
  output logic [INSTR_W-1:0]       instr_out,
  output logic                     instr_valid,
  output logic                     pc_enable,
  output logic                     next_instr,
  output logic                     jump,
  output logic                     cmp_jump,
  output logic signed [ADDR_W-1:0] jump_offset,
  output logic                     halted
);
  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT_EXEC, ADV_NEXT, ADV_JUMP, ADV_CMP, HALT} state_t;
  state_t state, state_nx;
  logic [INSTR_W-1:0] instr_reg;
  logic [3:0] opc;
  logic cond, ordinary;
  assign opc = instr_reg[INSTR_W-1 -: 4];
  assign cond = instr_reg[ADDR_W] ? flag_neg : flag_zero;
  assign ordinary = opc != OPC_JMP && opc != OPC_JCMP && opc != OPC_HALT;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      instr_reg <= '0;
    end else begin
      state <= state_nx;
      if (state == FETCH && imem_valid) instr_reg <= imem_data;
    end
  end
  // the advance kind is folded into the state so every PC strobe decodes from state alone
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:      state_nx = FETCH;
      FETCH:     state_nx = imem_valid ? ISSUE : FETCH;
      ISSUE:     state_nx = opc == OPC_JMP ? ADV_JUMP :
                            opc == OPC_JCMP ? (cond ? ADV_CMP : ADV_NEXT) :
                            opc == OPC_HALT ? HALT : WAIT_EXEC;
      WAIT_EXEC: state_nx = exec_done ? ADV_NEXT : WAIT_EXEC;
      ADV_NEXT, ADV_JUMP, ADV_CMP: state_nx = FETCH;
      HALT:      state_nx = HALT;
      default:   state_nx = IDLE;
    endcase
  end
  assign imem_rd = state == FETCH;
  assign imem_addr = imem_rd ? pc : '0;
  assign instr_out = instr_reg;
  assign instr_valid = state == ISSUE && ordinary;
  assign next_instr = state == ADV_NEXT;
  assign jump = state == ADV_JUMP;
  assign cmp_jump = state == ADV_CMP;
  assign pc_enable = next_instr | jump | cmp_jump;
  assign jump_offset = (jump | cmp_jump) ? instr_reg[ADDR_W-1:0] : '0;
  assign halted = state == HALT;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: random and directed instruction streams checked every cycle against a
// cycle-scheduled model of the fetch/issue/advance rules, plus literal pins on a directed program.
module tb_fetch_sequencer;
  logic clk = 0, reset_n = 0;
  logic [10:0] pc = 11'h100;
  logic [15:0] imem_data = 0;
  logic imem_valid = 0, flag_zero = 0, flag_neg = 0, exec_done = 0;
  logic [10:0] imem_addr;
  logic imem_rd, instr_valid, pc_enable, next_instr, jump, cmp_jump, halted;
  logic [15:0] instr_out;
  logic signed [10:0] jump_offset;

  fetch_sequencer dut (
    .clk(clk), .reset_n(reset_n), .pc(pc), .imem_addr(imem_addr), .imem_rd(imem_rd),
    .imem_data(imem_data), .imem_valid(imem_valid), .flag_zero(flag_zero), .flag_neg(flag_neg),
    .exec_done(exec_done), .instr_out(instr_out), .instr_valid(instr_valid), .pc_enable(pc_enable),
    .next_instr(next_instr), .jump(jump), .cmp_jump(cmp_jump), .jump_offset(jump_offset), .halted(halted)
  );

  always #5 clk = ~clk;
  // the PC counter this block drives
  always @(posedge clk) if (pc_enable) pc <= next_instr ? pc + 11'd1 : pc + jump_offset;

  int checks = 0, errors = 0, cyc = 0;
  int fetch_at, got, adv_at, halt_from, adv_kind;
  bit ord_wait, quiet;
  logic [15:0] ir;
  logic [10:0] mpc = 11'h100;
  int rd_cnt, ex_left, iv_cnt, didx;
  logic [15:0] cur_data;
  int cur_vd, cur_ed, iss_ed;
  bit cur_fz, cur_fn, iss_fz, iss_fn;
  logic [10:0] addr_q[$], off_q[$];
  int kind_q[$], rdlen_q[$], hs_q[$];

  logic [15:0] d_data[8] = '{16'h1234, 16'hE7FD, 16'hF005, 16'hF005, 16'hF805, 16'h5A5A, 16'hE000, 16'hD000};
  int d_vd[8] = '{0, 0, 0, 0, 0, 3, 0, 0};
  int d_ed[8] = '{2, 1, 1, 1, 1, 1, 1, 1};
  bit d_fz[8] = '{0, 0, 1, 0, 0, 0, 0, 0};
  bit d_fn[8] = '{0, 0, 0, 1, 1, 0, 0, 0};
  logic [10:0] e_addr[8] = '{11'h100, 11'h101, 11'h0FE, 11'h103, 11'h104, 11'h109, 11'h10A, 11'h10A};
  int e_kind[7] = '{0, 1, 2, 0, 2, 0, 1};
  logic [10:0] e_off[7] = '{11'h000, 11'h7FD, 11'h005, 11'h000, 11'h005, 11'h000, 11'h000};
  int e_rdlen[8] = '{1, 1, 1, 1, 1, 4, 1, 1};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic load_next();
    int r;
    logic [3:0] op;
    if (didx < 8) begin
      cur_data = d_data[didx]; cur_vd = d_vd[didx]; cur_ed = d_ed[didx];
      cur_fz = d_fz[didx]; cur_fn = d_fn[didx];
      didx++;
    end else begin
      r = $urandom_range(0, 39);
      op = r == 0 ? 4'hD : r < 9 ? 4'hE : r < 17 ? 4'hF : 4'($urandom_range(0, 12));
      cur_data = {op, 12'($urandom)};
      cur_vd = $urandom_range(0, 3); cur_ed = $urandom_range(1, 4);
      cur_fz = 1'($urandom); cur_fn = 1'($urandom);
    end
  endtask

  task automatic model_init();
    fetch_at = cyc + 1; got = -1; adv_at = -1; halt_from = -1; adv_kind = 0;
    ord_wait = 0; ir = 0; rd_cnt = 0; ex_left = -1;
  endtask

  task automatic check_cycle();
    bit f, adv, iv;
    logic [10:0] eo;
    f = fetch_at >= 0 && cyc >= fetch_at;
    adv = adv_at == cyc;
    iv = got >= 0 && cyc == got + 1 && ir[15:12] < 4'hD;
    eo = (adv && adv_kind != 0) ? ir[10:0] : 11'd0;
    chk("imem_rd", 32'(imem_rd), 32'(f));
    chk("imem_addr", 32'(imem_addr), f ? 32'(mpc) : 32'd0);
    chk("instr_out", 32'(instr_out), 32'(ir));
    chk("instr_valid", 32'(instr_valid), 32'(iv));
    chk("pc_enable", 32'(pc_enable), 32'(adv));
    chk("next_instr", 32'(next_instr), 32'(adv && adv_kind == 0));
    chk("jump", 32'(jump), 32'(adv && adv_kind == 1));
    chk("cmp_jump", 32'(cmp_jump), 32'(adv && adv_kind == 2));
    chk("jump_offset", 32'($unsigned(jump_offset)), 32'(eo));
    chk("halted", 32'(halted), 32'(halt_from >= 0 && cyc >= halt_from));
  endtask

  task automatic rst_checks();
    chk("rst_strobes", 32'({imem_rd, instr_valid, pc_enable, next_instr, jump, cmp_jump, halted}), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_instr", 32'(instr_out), 32'd0);
    chk("rst_offset", 32'($unsigned(jump_offset)), 32'd0);
  endtask

  task automatic drive_update();
    bit f;
    f = fetch_at >= 0 && cyc >= fetch_at;
    if (got >= 0 && cyc == got + 1) {flag_zero, flag_neg} = {iss_fz, iss_fn};
    else {flag_zero, flag_neg} = 2'($urandom);
    imem_valid = imem_rd ? rd_cnt == cur_vd : (!quiet && $urandom_range(0, 3) == 0);
    imem_data = (imem_rd && imem_valid) ? cur_data : 16'($urandom);
    exec_done = ex_left == 0 || (!quiet && $urandom_range(0, 9) == 0);
    if (f && imem_valid) begin
      got = cyc; fetch_at = -1; ir = imem_data;
      addr_q.push_back(imem_addr); hs_q.push_back(cyc);
      iss_ed = cur_ed; iss_fz = cur_fz; iss_fn = cur_fn;
      if (ir[15:12] == 4'hE) begin adv_at = cyc + 2; adv_kind = 1; end
      else if (ir[15:12] == 4'hD) halt_from = cyc + 2;
      else if (ir[15:12] < 4'hD) ord_wait = 1;
      load_next();
    end else if (got >= 0 && cyc == got + 1 && ir[15:12] == 4'hF) begin
      adv_at = cyc + 1;
      adv_kind = (ir[11] ? flag_neg : flag_zero) ? 2 : 0;
    end else if (ord_wait && cyc >= got + 2 && exec_done) begin
      adv_at = cyc + 1; adv_kind = 0; ord_wait = 0;
    end
    if (adv_at == cyc) begin
      fetch_at = cyc + 1;
      mpc = adv_kind == 0 ? mpc + 11'd1 : mpc + ir[10:0];
      kind_q.push_back(adv_kind);
      off_q.push_back(adv_kind != 0 ? ir[10:0] : 11'd0);
    end
    if (imem_rd && imem_valid) begin rdlen_q.push_back(rd_cnt + 1); rd_cnt = 0; end
    else if (imem_rd) rd_cnt++;
    if (instr_valid) begin ex_left = iss_ed - 1; iv_cnt++; end
    else if (ex_left >= 0) ex_left--;
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
    drive_update();
    @(posedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    logic [10:0] saved;
    @(negedge clk);
    check_cycle();
    #2 reset_n = 0;
    saved = pc;
    #1 rst_checks();
    @(posedge clk);
    cyc++;
    #1 chk("rst_no_pc_strobe", 32'(pc), 32'(saved));
    @(negedge clk);
    reset_n = 1;
    model_init();
    drive_update();
    @(posedge clk);
    cyc++;
  endtask

  initial begin
    int n;
    didx = 0; quiet = 0; iv_cnt = 0;
    load_next();
    model_init();
    @(posedge clk);
    @(negedge clk);
    rst_checks();
    reset_n = 1;
    cyc = 0;
    model_init();
    drive_update();
    @(posedge clk);
    cyc++;
    n = 0;
    while (!(halt_from >= 0 && cyc >= halt_from + 25) && n < 2000) begin tick(); n++; end
    chk("directed_halt_reached", 32'(n < 2000), 32'd1);
    #1 chk("halt_hold", 32'({halted, imem_rd, pc_enable, instr_valid}), 32'b1000);
    chk("directed_fetches", 32'(addr_q.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("fetch_addr_%0d", i), 32'(addr_q[i]), 32'(e_addr[i]));
      chk($sformatf("rd_len_%0d", i), 32'(rdlen_q[i]), 32'(e_rdlen[i]));
    end
    chk("directed_advances", 32'(kind_q.size()), 32'd7);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("adv_kind_%0d", i), 32'(kind_q[i]), 32'(e_kind[i]));
      chk($sformatf("adv_off_%0d", i), 32'(off_q[i]), 32'(e_off[i]));
    end
    chk("jump_throughput", 32'(hs_q[2] - hs_q[1]), 32'd3);
    chk("issue_pulses", 32'(iv_cnt), 32'd2);
    do_reset();
    cur_data = 16'h3ABC; cur_vd = 1; cur_ed = 60; quiet = 1;
    n = 0;
    while (!(ord_wait && cyc >= got + 4) && n < 40) begin tick(); n++; end
    chk("mid_exec_reached", 32'(ord_wait), 32'd1);
    do_reset();
    quiet = 0;
    for (int i = 0; i < 4000; i++) begin
      tick();
      if (halt_from >= 0 && cyc >= halt_from && $urandom_range(0, 9) == 0) do_reset();
      else if ($urandom_range(0, 299) == 0) do_reset();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
